// File: rtl/cpu_defs.sv
// Shared definitions for the multicycle 16-bit processor:
// opcodes, PC source encodings and instruction field positions.
package cpu_defs;

   localparam int CPU_WIDTH = 16;
   localparam int CPU_OPW   = 6;

   typedef enum logic [5:0] {
      C_TYPE  = 6'd0,
      BIEQ    = 6'd1,
      BNEQ    = 6'd2,
      J       = 6'd3,
      JAL     = 6'd4,
      JR      = 6'd5,
      LUI     = 6'd6,
      LLI     = 6'd7,
      LTR     = 6'd8,
      CTR     = 6'd9,
      LW      = 6'd10,
      SW      = 6'd11,
      SYSCALL = 6'd12,
      OP_IDLE = 6'h3F
   } opcode_e;

   typedef enum logic [1:0] {
      PCSRC_ALU  = 2'd0,
      PCSRC_JUMP = 2'd1,
      PCSRC_REG  = 2'd2,
      PCSRC_EXC  = 2'd3
   } pcsrc_e;

   localparam int OP_MSB  = 15;
   localparam int OP_LSB  = 10;
   localparam int SEL_MSB = 9;
   localparam int SEL_LSB = 8;
   localparam int IMM_MSB = 7;
   localparam int FN_MSB  = 3;
   localparam int JT_MSB  = 9;

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Control and memory bundle between control_unit, memory and the
// fetch/PC stage.
interface fetch_pc_unit_if #(
   parameter int WIDTH = 16,
   parameter int OPW   = 6
);
   logic             IRWrite;
   logic             PCWrite;
   logic             isBranch;
   logic [1:0]       PCSrc;
   logic [WIDTH-1:0] alu_result;
   logic             alu_zero;
   logic [WIDTH-1:0] reg_data;
   logic [WIDTH-1:0] mem_rdata;
   logic             mem_ready;
   logic [WIDTH-1:0] pc;
   logic [WIDTH-1:0] old_pc;
   logic [OPW-1:0]   Opcode;
   logic [1:0]       reg_sel;
   logic [7:0]       imm8;
   logic [3:0]       funct;
   logic [WIDTH-1:0] mdr;
   logic             fetch_stall;
   logic [WIDTH-1:0] retired;

   modport master (
      output IRWrite, PCWrite, isBranch, PCSrc,
      output alu_result, alu_zero, reg_data,
      output mem_rdata, mem_ready,
      input  pc, old_pc, Opcode, reg_sel, imm8, funct,
      input  mdr, fetch_stall, retired
   );

   modport slave (
      input  IRWrite, PCWrite, isBranch, PCSrc,
      input  alu_result, alu_zero, reg_data,
      input  mem_rdata, mem_ready,
      output pc, old_pc, Opcode, reg_sel, imm8, funct,
      output mdr, fetch_stall, retired
   );
endinterface

// File: rtl/next_pc_mux.sv
// Next-PC source selection and conditional branch resolution.
// Purely combinational.
module next_pc_mux
   import cpu_defs::*;
#(
   parameter int               WIDTH      = 16,
   parameter logic [WIDTH-1:0] EXC_VECTOR = 16'h0004
) (
   input  logic [WIDTH-12:0] pc_hi,
   input  logic [JT_MSB:0]   jidx,
   input  logic [5:0]        opcode,
   input  pcsrc_e            pcsrc,
   input  logic              is_branch,
   input  logic [WIDTH-1:0]  alu_result,
   input  logic              alu_zero,
   input  logic [WIDTH-1:0]  reg_data,
   output logic [WIDTH-1:0]  next_pc,
   output logic              taken
);

   // Branch condition: BIEQ on zero, BNEQ on non-zero, else never.
   always_comb begin
      taken = 1'b0;
      if (is_branch) begin
         if (opcode == BIEQ)
            taken = alu_zero;
         else if (opcode == BNEQ)
            taken = ~alu_zero;
      end
   end

   // PC source mux; jump target keeps the PC page and is always even.
   always_comb begin
      next_pc = alu_result;
      unique case (pcsrc)
         PCSRC_ALU:  next_pc = alu_result;
         PCSRC_JUMP: next_pc = {pc_hi, jidx, 1'b0};
         PCSRC_REG:  next_pc = reg_data;
         PCSRC_EXC:  next_pc = EXC_VECTOR;
      endcase
   end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch stage: PC, IR, MDR, fetch-PC latch and retired counter,
// with IR field decode and memory-wait stall qualifier.
module fetch_pc_unit
   import cpu_defs::*;
#(
   parameter int               WIDTH      = 16,
   parameter int               OPW        = 6,
   parameter logic [WIDTH-1:0] RESET_PC   = 16'h0000,
   parameter logic [WIDTH-1:0] EXC_VECTOR = 16'h0004
) (
   input  logic           CLK,
   input  logic           Reset,
   fetch_pc_unit_if.slave bus
);

   logic [WIDTH-1:0] pc_q;
   logic [WIDTH-1:0] old_pc_q;
   logic [WIDTH-1:0] ir_q;
   logic [WIDTH-1:0] mdr_q;
   logic [WIDTH-1:0] retired_q;
   logic [WIDTH-1:0] next_pc;
   logic             taken;
   logic             stall;
   logic             capture;
   logic             pc_we;

   assign stall   = bus.IRWrite & ~bus.mem_ready;
   assign capture = bus.IRWrite & bus.mem_ready;
   assign pc_we   = ~stall & (bus.PCWrite | taken);

   next_pc_mux #(
      .WIDTH      (WIDTH),
      .EXC_VECTOR (EXC_VECTOR)
   ) u_mux (
      .pc_hi      (pc_q[WIDTH-1:11]),
      .jidx       (ir_q[JT_MSB:0]),
      .opcode     (ir_q[OP_MSB:OP_LSB]),
      .pcsrc      (pcsrc_e'(bus.PCSrc)),
      .is_branch  (bus.isBranch),
      .alu_result (bus.alu_result),
      .alu_zero   (bus.alu_zero),
      .reg_data   (bus.reg_data),
      .next_pc    (next_pc),
      .taken      (taken)
   );

   // PC register: written on jump/branch/increment unless fetch is stalled.
   always_ff @(posedge CLK) begin
      if (Reset)
         pc_q <= RESET_PC;
      else if (pc_we)
         pc_q <= next_pc;
   end

   // Instruction capture: IR, fetch-PC latch and retired count move together.
   always_ff @(posedge CLK) begin
      if (Reset) begin
         ir_q      <= '1;
         old_pc_q  <= RESET_PC;
         retired_q <= '0;
      end else if (capture) begin
         ir_q      <= bus.mem_rdata;
         old_pc_q  <= pc_q;
         retired_q <= retired_q + 1'b1;
      end
   end

   // MDR latches every valid memory beat, fetch or data.
   always_ff @(posedge CLK) begin
      if (Reset)
         mdr_q <= '0;
      else if (bus.mem_ready)
         mdr_q <= bus.mem_rdata;
   end

   assign bus.pc          = pc_q;
   assign bus.old_pc      = old_pc_q;
   assign bus.Opcode      = ir_q[WIDTH-1 -: OPW];
   assign bus.reg_sel     = ir_q[SEL_MSB:SEL_LSB];
   assign bus.imm8        = ir_q[IMM_MSB:0];
   assign bus.funct       = ir_q[FN_MSB:0];
   assign bus.mdr         = mdr_q;
   assign bus.fetch_stall = stall;
   assign bus.retired     = retired_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: reset, fetch, jump, branches,
// PC sources, memory stall and reset during a stalled fetch.
module tb_fetch_pc_unit;

   logic CLK = 1'b0;
   logic Reset;
   int   n_chk  = 0;
   int   n_fail = 0;

   fetch_pc_unit_if #(.WIDTH(16), .OPW(6)) bus ();

   fetch_pc_unit #(
      .WIDTH      (16),
      .OPW        (6),
      .RESET_PC   (16'h0000),
      .EXC_VECTOR (16'h0004)
   ) dut (
      .CLK   (CLK),
      .Reset (Reset),
      .bus   (bus)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [15:0] obs,
                      input logic [15:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle();
      bus.IRWrite  = 1'b0;
      bus.PCWrite  = 1'b0;
      bus.isBranch = 1'b0;
      bus.PCSrc    = 2'd0;
      bus.mem_ready = 1'b0;
   endtask

   initial begin
      Reset          = 1'b1;
      bus.alu_result = 16'h0;
      bus.alu_zero   = 1'b0;
      bus.reg_data   = 16'h0;
      bus.mem_rdata  = 16'h0;
      idle();
      step();
      step();
      Reset = 1'b0;
      chk("rst_pc", bus.pc, 16'h0000);
      chk("rst_oldpc", bus.old_pc, 16'h0000);
      chk("rst_op", 16'(bus.Opcode), 16'h003F);
      chk("rst_ret", bus.retired, 16'h0000);
      chk("rst_mdr", bus.mdr, 16'h0000);
      chk("rst_stall", 16'(bus.fetch_stall), 16'h0);

      // fetch 0C12 with PC<=PC+2
      bus.IRWrite    = 1'b1;
      bus.PCWrite    = 1'b1;
      bus.PCSrc      = 2'd0;
      bus.mem_ready  = 1'b1;
      bus.mem_rdata  = 16'h0C12;
      bus.alu_result = 16'h0002;
      #1 chk("f1_stall", 16'(bus.fetch_stall), 16'h0);
      step();
      chk("f1_op", 16'(bus.Opcode), 16'h0003);
      chk("f1_oldpc", bus.old_pc, 16'h0000);
      chk("f1_pc", bus.pc, 16'h0002);
      chk("f1_ret", bus.retired, 16'h0001);
      chk("f1_imm", 16'(bus.imm8), 16'h0012);
      chk("f1_fn", 16'(bus.funct), 16'h0002);
      chk("f1_sel", 16'(bus.reg_sel), 16'h0000);
      chk("f1_mdr", bus.mdr, 16'h0C12);

      // capture J 0D05 without moving PC, then jump
      bus.PCWrite   = 1'b0;
      bus.mem_rdata = 16'h0D05;
      step();
      chk("j_ir_op", 16'(bus.Opcode), 16'h0003);
      chk("j_ir_sel", 16'(bus.reg_sel), 16'h0001);
      chk("j_oldpc", bus.old_pc, 16'h0002);
      chk("j_ret", bus.retired, 16'h0002);
      idle();
      bus.PCWrite = 1'b1;
      bus.PCSrc   = 2'd1;
      step();
      chk("j_pc", bus.pc, 16'h020A);

      // BIEQ
      idle();
      bus.IRWrite   = 1'b1;
      bus.mem_ready = 1'b1;
      bus.mem_rdata = 16'h0410;
      step();
      chk("bieq_op", 16'(bus.Opcode), 16'h0001);
      chk("bieq_oldpc", bus.old_pc, 16'h020A);
      idle();
      bus.isBranch   = 1'b1;
      bus.alu_result = 16'h0040;
      bus.alu_zero   = 1'b1;
      step();
      chk("bieq_take", bus.pc, 16'h0040);
      bus.alu_result = 16'h0080;
      bus.alu_zero   = 1'b0;
      step();
      chk("bieq_not", bus.pc, 16'h0040);

      // BNEQ
      idle();
      bus.IRWrite   = 1'b1;
      bus.mem_ready = 1'b1;
      bus.mem_rdata = 16'h0810;
      step();
      chk("bneq_op", 16'(bus.Opcode), 16'h0002);
      chk("bneq_ret", bus.retired, 16'h0004);
      idle();
      bus.isBranch   = 1'b1;
      bus.alu_result = 16'h0080;
      bus.alu_zero   = 1'b1;
      step();
      chk("bneq_not", bus.pc, 16'h0040);
      bus.alu_zero = 1'b0;
      step();
      chk("bneq_take", bus.pc, 16'h0080);

      // PCWrite OR isBranch even when branch not taken
      bus.PCWrite    = 1'b1;
      bus.alu_zero   = 1'b1;
      bus.alu_result = 16'h00A0;
      step();
      chk("or_wr", bus.pc, 16'h00A0);

      // register and exception sources
      idle();
      bus.PCWrite  = 1'b1;
      bus.PCSrc    = 2'd2;
      bus.reg_data = 16'h1234;
      step();
      chk("jr_pc", bus.pc, 16'h1234);
      bus.PCSrc = 2'd3;
      step();
      chk("exc_pc", bus.pc, 16'h0004);

      // stalled fetch: 3 wait cycles then capture
      idle();
      bus.IRWrite    = 1'b1;
      bus.PCWrite    = 1'b1;
      bus.PCSrc      = 2'd0;
      bus.alu_result = 16'h0100;
      bus.mem_rdata  = 16'h0C55;
      for (int i = 0; i < 3; i++) begin
         #1 chk("st_stall", 16'(bus.fetch_stall), 16'h1);
         step();
         chk("st_pc", bus.pc, 16'h0004);
         chk("st_op", 16'(bus.Opcode), 16'h0002);
         chk("st_ret", bus.retired, 16'h0004);
         chk("st_mdr", bus.mdr, 16'h0810);
      end
      bus.mem_ready = 1'b1;
      #1 chk("st_rel", 16'(bus.fetch_stall), 16'h0);
      step();
      chk("st_cap_op", 16'(bus.Opcode), 16'h0003);
      chk("st_cap_imm", 16'(bus.imm8), 16'h0055);
      chk("st_cap_pc", bus.pc, 16'h0100);
      chk("st_cap_old", bus.old_pc, 16'h0004);
      chk("st_cap_ret", bus.retired, 16'h0005);

      // data read: MDR only
      idle();
      bus.mem_ready = 1'b1;
      bus.mem_rdata = 16'hBEEF;
      step();
      chk("mdr_data", bus.mdr, 16'hBEEF);
      chk("mdr_op", 16'(bus.Opcode), 16'h0003);
      chk("mdr_ret", bus.retired, 16'h0005);

      // reset during a stalled fetch
      idle();
      bus.IRWrite    = 1'b1;
      bus.PCWrite    = 1'b1;
      bus.alu_result = 16'h0200;
      bus.mem_rdata  = 16'h0C77;
      Reset = 1'b1;
      step();
      chk("rs_pc", bus.pc, 16'h0000);
      chk("rs_op", 16'(bus.Opcode), 16'h003F);
      chk("rs_ret", bus.retired, 16'h0000);
      chk("rs_mdr", bus.mdr, 16'h0000);
      Reset = 1'b0;
      idle();
      bus.mem_ready = 1'b1;
      step();
      chk("rs_nocap_op", 16'(bus.Opcode), 16'h003F);
      chk("rs_nocap_ret", bus.retired, 16'h0000);
      chk("rs_nocap_pc", bus.pc, 16'h0000);
      chk("rs_mdr2", bus.mdr, 16'h0C77);

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Datapath stage directly upstream of control_unit in the multicycle 16-bit processor.
- Holds the PC, the instruction register (IR), the memory data register (MDR), the fetch-PC latch and a retired-instruction counter.
- Decodes IR fields, including the 6-bit Opcode consumed by control_unit.
- Applies control_unit's PCWrite/isBranch/PCSrc/IRWrite to update PC and IR, and stalls fetch on a slow memory handshake.

Parameters:
- WIDTH, 16, datapath/instruction width
- OPW, 6, opcode width (IR[15:10])
- RESET_PC, 16'h0000, PC value after reset
- EXC_VECTOR, 16'h0004, PC target for PCSrc=3 (SYSCALL)

Ports:
- CLK  in  1  single clock, rising edge
- Reset  in  1  synchronous, active-high reset
- IRWrite  in  1  from control_unit: capture mem_rdata into IR
- PCWrite  in  1  from control_unit: unconditional PC write
- isBranch  in  1  from control_unit: conditional PC write
- PCSrc  in  2  from control_unit: 0=alu_result, 1=jump target, 2=reg_data, 3=EXC_VECTOR
- alu_result  in  16  ALU output (PC+2 or branch target)
- alu_zero  in  1  ALU zero flag from branch compare
- reg_data  in  16  register-file read data, used for JR
- mem_rdata  in  16  memory read data
- mem_ready  in  1  memory read data valid this cycle
- pc  out  16  current PC (memory address when IorD=0)
- old_pc  out  16  PC of the instruction in IR (JAL link, branch base)
- Opcode  out  6  IR[15:10], to control_unit
- reg_sel  out  2  IR[9:8]
- imm8  out  8  IR[7:0]
- funct  out  4  IR[3:0], C-type ALU function
- mdr  out  16  memory data register
- fetch_stall  out  1  to control_unit: hold the current state
- retired  out  16  count of IR captures

Behaviour:
- Reset: applies on the rising CLK edge when Reset=1 and overrides every other input that cycle.
  - pc=RESET_PC, old_pc=RESET_PC.
  - IR=16'hFFFF, so Opcode=6'h3F (idle/illegal).
  - mdr=0, retired=0.
- Reset mid-fetch discards the pending fetch. No output is combinationally affected by Reset other than through the registers.
- Jump target = {pc[15:11], IR[9:0], 1'b0}. An odd address never results.
- fetch_stall = IRWrite & ~mem_ready (combinational). While it is high:
  - IR, pc, old_pc and retired hold.
  - PCWrite/isBranch are ignored that cycle.
- IR capture, when IRWrite=1 and mem_ready=1 on the edge:
  - IR<=mem_rdata.
  - old_pc<=pc.
  - retired<=retired+1, wrapping FFFF->0000.
- mdr<=mem_rdata on every edge where mem_ready=1, independent of IRWrite.
- taken = isBranch & ((Opcode==1) ? alu_zero : (Opcode==2) ? ~alu_zero : 0). BIEQ=1, BNEQ=2.
- PC write, when fetch_stall=0 and (PCWrite | taken): pc<=mux(PCSrc). Otherwise pc holds.
- Simultaneous IR capture and PC write in the same cycle (the fetch cycle does PC<=PC+2): old_pc gets the pre-write pc, pc gets the new value, IR gets the new instruction.
- PCWrite=1 with isBranch=1: the write occurs (OR semantics).
- Zero latency on decoded fields: Opcode, reg_sel, imm8 and funct change in the cycle after IR capture.
- No internal FSM beyond the stall qualifier. Sequencing is owned by control_unit; this block is registers plus next-PC and stall logic.

Decomposition:
- Shared package cpu_defs holds:
  - opcode constants (C_TYPE=0, BIEQ=1, BNEQ=2, J=3, JAL=4, JR=5, LUI=6, LLI=7, LTR=8, CTR=9, LW=10, SW=11, SYSCALL=12, OP_IDLE=6'h3F);
  - PCSrc encodings (PCSRC_ALU, PCSRC_JUMP, PCSRC_REG, PCSRC_EXC);
  - IR field bit positions.
- One sub-module, next_pc_mux: combinational selection of the PC source plus the taken logic.

Test Plan:
- Reset=1 for 2 cycles, then release -> pc=0000, Opcode=3F, retired=0, fetch_stall=0.
- IRWrite=1, PCWrite=1, PCSrc=0, mem_ready=1, mem_rdata=16'h0C12, alu_result=0002 -> next cycle Opcode=03, old_pc=0000, pc=0002, retired=1.
- Opcode=J, IR=16'h0D05, pc=0002, PCWrite=1, PCSrc=1 -> pc=020A.
- BIEQ: isBranch=1, alu_result=0040. With alu_zero=1 -> pc=0040. Repeat with alu_zero=0 -> pc unchanged. BNEQ: same stimulus gives the inverse result.
- IRWrite=1, mem_ready=0 for 3 cycles, then 1 -> fetch_stall high for 3 cycles; IR and pc hold during the stall; capture happens on the 4th edge; retired increments by exactly 1.
- Assert Reset during a stalled fetch with PCWrite=1 -> pc=RESET_PC, IR=FFFF, retired=0, and the stale capture never occurs after release.
